// File: rtl/div_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// div_sequencer_pkg
// Shared definitions for the divide unit:
//   - muldiv_op_e  : shared MUL/DIV op encoding. Only DIV/REM reach this unit;
//                    signedness travels on separate flags.
//   - RS_DIV       : reservation-station / issue-port id of the divide unit.
//   - div_state_e  : 3-bit FSM state encoding of div_sequencer.
//   - XLEN_DEFAULT : default operand width.
// -----------------------------------------------------------------------------
package div_sequencer_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int RS_DIV       = 3;

    typedef enum logic [1:0] {
        MULDIV_MUL  = 2'b00,
        MULDIV_MULH = 2'b01,
        MULDIV_DIV  = 2'b10,
        MULDIV_REM  = 2'b11
    } muldiv_op_e;

    typedef enum logic [2:0] {
        DIV_IDLE = 3'd0,
        DIV_PREP = 3'd1,
        DIV_CALC = 3'd2,
        DIV_FIX  = 3'd3,
        DIV_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_sequencer_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational iteration of radix-2 restoring division.
// Ports:
//   rem_i      : partial remainder (always < divisor)
//   dvd_msb_i  : next dividend bit shifted into the remainder
//   dvs_i      : divisor (magnitude)
//   rem_o      : next partial remainder
//   q_bit_o    : quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dvd_msb_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;

    // The shifted remainder needs XLEN+1 bits: with a divisor near 2^XLEN the
    // remainder MSB can be set, and dropping it would corrupt the result.
    assign shifted = {rem_i, dvd_msb_i};
    assign q_bit_o = (shifted >= {1'b0, dvs_i});
    // When the subtraction is taken the result is < divisor, so it fits XLEN bits.
    assign diff    = shifted[XLEN-1:0] - dvs_i;
    assign rem_o   = q_bit_o ? diff : shifted[XLEN-1:0];

endmodule

// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
// Multi-cycle integer DIV/DIVU/REM/REMU unit (restoring division, one quotient
// bit per cycle) with RISC-V divide-by-zero and signed-overflow handling.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   flush              : abort in-flight op, drop pending result
//   req_valid/ready    : request handshake (ready only in IDLE)
//   req_op             : MULDIV_DIV -> quotient, MULDIV_REM -> remainder
//   req_rs1/2_signed   : per-operand signedness
//   req_src1/src2      : dividend / divisor
//   req_tag            : ROB tag
//   resp_valid/ready   : response handshake
//   resp_data/resp_tag : result and its tag, stable while resp_valid
//   busy               : FSM not in IDLE
// -----------------------------------------------------------------------------
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic             req_rs1_signed,
    input  logic             req_rs2_signed,
    input  logic [XLEN-1:0]  req_src1,
    input  logic [XLEN-1:0]  req_src2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q;     // partial remainder
    logic [XLEN-1:0]  dvd_q;     // dividend, becomes quotient as bits shift in
    logic [XLEN-1:0]  dvs_q;     // divisor
    logic             s1_q;
    logic             s2_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             is_rem_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  resp_data_q;
    logic [TAG_W-1:0] resp_tag_q;
    logic             resp_valid_q;
    logic             req_ready_q;
    logic             busy_q;

    logic [XLEN-1:0]  rem_d;
    logic             q_bit_d;

    logic             sign1;
    logic             sign2;
    logic [XLEN-1:0]  abs1;
    logic [XLEN-1:0]  abs2;
    logic             div_zero;
    logic             sovf;
    logic [XLEN-1:0]  quot_fix;
    logic [XLEN-1:0]  rem_fix;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[XLEN-1]),
        .dvs_i     (dvs_q),
        .rem_o     (rem_d),
        .q_bit_o   (q_bit_d)
    );

    // Operand conditioning, meaningful while in PREP (registers hold raw operands).
    always_comb begin
        sign1    = s1_q & dvd_q[XLEN-1];
        sign2    = s2_q & dvs_q[XLEN-1];
        abs1     = sign1 ? -dvd_q : dvd_q;
        abs2     = sign2 ? -dvs_q : dvs_q;
        div_zero = (dvs_q == '0);
        sovf     = s1_q && s2_q &&
                   (dvd_q == {1'b1, {(XLEN-1){1'b0}}}) && (dvs_q == '1);
        quot_fix = q_neg_q ? -dvd_q : dvd_q;
        rem_fix  = r_neg_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= DIV_IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            dvd_q        <= '0;
            dvs_q        <= '0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            is_rem_q     <= 1'b0;
            tag_q        <= '0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else if (flush) begin
            // Covers DONE with resp_ready high: the result is dropped.
            state_q      <= DIV_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (req_valid) begin
                        dvd_q       <= req_src1;
                        dvs_q       <= req_src2;
                        s1_q        <= req_rs1_signed;
                        s2_q        <= req_rs2_signed;
                        is_rem_q    <= (req_op == MULDIV_REM);
                        tag_q       <= req_tag;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= DIV_PREP;
                    end
                end
                DIV_PREP: begin
                    // Special cases preload quotient/remainder and pass through
                    // FIX, which does the DIV/REM selection for every path.
                    if (div_zero) begin
                        dvd_q   <= '1;
                        rem_q   <= dvd_q;
                        q_neg_q <= 1'b0;
                        r_neg_q <= 1'b0;
                        state_q <= DIV_FIX;
                    end else if (sovf) begin
                        dvd_q   <= {1'b1, {(XLEN-1){1'b0}}};
                        rem_q   <= '0;
                        q_neg_q <= 1'b0;
                        r_neg_q <= 1'b0;
                        state_q <= DIV_FIX;
                    end else begin
                        dvd_q   <= abs1;
                        dvs_q   <= abs2;
                        rem_q   <= '0;
                        q_neg_q <= sign1 ^ sign2;
                        r_neg_q <= sign1;
                        cnt_q   <= CNT_W'(XLEN - 1);
                        state_q <= DIV_CALC;
                    end
                end
                DIV_CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= {dvd_q[XLEN-2:0], q_bit_d};
                    if (cnt_q == '0) begin
                        state_q <= DIV_FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DIV_FIX: begin
                    resp_data_q  <= is_rem_q ? rem_fix : quot_fix;
                    resp_tag_q   <= tag_q;
                    resp_valid_q <= 1'b1;
                    state_q      <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= DIV_IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= DIV_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_tag   = resp_tag_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_sequencer
// Directed, table-driven bench for div_sequencer plus hand-written sequences
// for backpressure, flush and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_rs1_signed;
    logic        req_rs2_signed;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic [5:0]  req_tag;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [5:0]  resp_tag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic        s1;
        logic        s2;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    div_sequencer #(.XLEN(32), .TAG_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_rs1_signed (req_rs1_signed),
        .req_rs2_signed (req_rs2_signed),
        .req_src1       (req_src1),
        .req_src2       (req_src2),
        .req_tag        (req_tag),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_tag       (resp_tag),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge with the unit idle; accept on the next edge.
    task automatic issue(input logic [1:0] op, input logic s1, input logic s2,
                         input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
        req_op         = op;
        req_rs1_signed = s1;
        req_rs2_signed = s2;
        req_src1       = a;
        req_src2       = b;
        req_tag        = tag;
        req_valid      = 1'b1;
        @(posedge clk);
        #1;
        req_valid      = 1'b0;
    endtask

    // Counts edges after the accept edge until resp_valid is seen (bounded).
    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!resp_valid && lat < 200);
    endtask

    task automatic complete();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        issue(v.op, v.s1, v.s2, v.a, v.b, v.tag);
        wait_resp(lat);
        chk($sformatf("vec%0d_latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("vec%0d_data", idx), resp_data, v.exp);
        chk($sformatf("vec%0d_tag", idx), {26'b0, resp_tag}, {26'b0, v.tag});
        complete();
    endtask

    initial begin
        int  lat;
        logic seen;

        rst            = 1'b1;
        flush          = 1'b0;
        req_valid      = 1'b0;
        req_op         = MULDIV_DIV;
        req_rs1_signed = 1'b0;
        req_rs2_signed = 1'b0;
        req_src1       = '0;
        req_src2       = '0;
        req_tag        = '0;
        resp_ready     = 1'b0;

        //           op          s1    s2    dividend       divisor        tag    expected       lat
        vecs[0]  = '{MULDIV_DIV, 1'b0, 1'b0, 32'd100,       32'd7,         6'd5,  32'd14,        34};
        vecs[1]  = '{MULDIV_REM, 1'b0, 1'b0, 32'd100,       32'd7,         6'd6,  32'd2,         34};
        vecs[2]  = '{MULDIV_DIV, 1'b1, 1'b1, 32'hFFFFFFF9,  32'd2,         6'd7,  32'hFFFFFFFD,  34};
        vecs[3]  = '{MULDIV_REM, 1'b1, 1'b1, 32'hFFFFFFF9,  32'd2,         6'd8,  32'hFFFFFFFF,  34};
        vecs[4]  = '{MULDIV_DIV, 1'b1, 1'b1, 32'd7,         32'hFFFFFFFE,  6'd9,  32'hFFFFFFFD,  34};
        vecs[5]  = '{MULDIV_REM, 1'b1, 1'b1, 32'd7,         32'hFFFFFFFE,  6'd10, 32'd1,         34};
        vecs[6]  = '{MULDIV_DIV, 1'b0, 1'b0, 32'h1234,      32'd0,         6'd11, 32'hFFFFFFFF,  2};
        vecs[7]  = '{MULDIV_REM, 1'b1, 1'b1, 32'h1234,      32'd0,         6'd12, 32'h1234,      2};
        vecs[8]  = '{MULDIV_DIV, 1'b1, 1'b1, 32'h80000000,  32'hFFFFFFFF,  6'd13, 32'h80000000,  2};
        vecs[9]  = '{MULDIV_REM, 1'b1, 1'b1, 32'h80000000,  32'hFFFFFFFF,  6'd14, 32'd0,         2};
        vecs[10] = '{MULDIV_DIV, 1'b0, 1'b0, 32'hFFFFFFFF,  32'hFFFFFFFE,  6'd15, 32'd1,         34};
        vecs[11] = '{MULDIV_REM, 1'b0, 1'b0, 32'hFFFFFFFF,  32'hFFFFFFFE,  6'd16, 32'd1,         34};
        vecs[12] = '{MULDIV_DIV, 1'b0, 1'b0, 32'h80000000,  32'hFFFFFFFF,  6'd17, 32'd0,         34};
        vecs[13] = '{MULDIV_REM, 1'b0, 1'b0, 32'h80000000,  32'hFFFFFFFF,  6'd18, 32'h80000000,  34};
        vecs[14] = '{MULDIV_DIV, 1'b1, 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  6'd19, 32'd14,        34};
        vecs[15] = '{MULDIV_REM, 1'b1, 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  6'd20, 32'hFFFFFFFE,  34};
        vecs[16] = '{MULDIV_REM, 1'b1, 1'b1, 32'hFFFFFFF8,  32'd0,         6'd21, 32'hFFFFFFF8,  2};
        vecs[17] = '{MULDIV_DIV, 1'b1, 1'b1, 32'd0,         32'd5,         6'd63, 32'd0,         34};
        vecs[18] = '{MULDIV_REM, 1'b0, 1'b0, 32'd5,         32'd100,       6'd0,  32'd5,         34};

        // Reset state, before any clock edge
        #2;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_req_ready",  {31'b0, req_ready},  32'd1);
        chk("rst_busy",       {31'b0, busy},       32'd0);
        chk("rst_resp_data",  resp_data,           32'd0);
        chk("rst_resp_tag",   {26'b0, resp_tag},   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: result held for 10 cycles, then released
        issue(MULDIV_DIV, 1'b0, 1'b0, 32'd100, 32'd7, 6'd42);
        chk("bp_busy_after_accept", {31'b0, busy}, 32'd1);
        wait_resp(lat);
        chk("bp_latency", 32'(lat), 32'd34);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_valid", i), {31'b0, resp_valid}, 32'd1);
            chk($sformatf("bp_hold%0d_data", i), resp_data, 32'd14);
            chk($sformatf("bp_hold%0d_tag", i), {26'b0, resp_tag}, 32'd42);
            chk($sformatf("bp_hold%0d_req_ready", i), {31'b0, req_ready}, 32'd0);
        end
        complete();
        chk("bp_release_valid", {31'b0, resp_valid}, 32'd0);
        chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
        chk("bp_release_busy",  {31'b0, busy},      32'd0);
        issue(MULDIV_REM, 1'b0, 1'b0, 32'd100, 32'd7, 6'd43);
        chk("bp_next_accepted", {31'b0, busy}, 32'd1);
        wait_resp(lat);
        chk("bp_next_data", resp_data, 32'd2);
        chk("bp_next_tag", {26'b0, resp_tag}, 32'd43);
        complete();

        // Flush at CALC cycle 15
        issue(MULDIV_DIV, 1'b0, 1'b0, 32'd1000, 32'd3, 6'd30);
        repeat (16) @(posedge clk);
        #1;
        chk("fl_calc_busy_before", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl_calc_busy",      {31'b0, busy},       32'd0);
        chk("fl_calc_req_ready", {31'b0, req_ready},  32'd1);
        seen = resp_valid;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            seen = seen | resp_valid;
        end
        chk("fl_calc_no_resp", {31'b0, seen}, 32'd0);

        // Flush together with req_valid: not accepted
        req_op         = MULDIV_DIV;
        req_rs1_signed = 1'b0;
        req_rs2_signed = 1'b0;
        req_src1       = 32'd9;
        req_src2       = 32'd0;
        req_tag        = 6'd31;
        req_valid      = 1'b1;
        flush          = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("fl_req_busy",      {31'b0, busy},      32'd0);
        chk("fl_req_req_ready", {31'b0, req_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("fl_req_no_resp", {31'b0, resp_valid}, 32'd0);

        // Flush together with resp_ready in DONE: result dropped
        issue(MULDIV_DIV, 1'b0, 1'b0, 32'h1234, 32'd0, 6'd3);
        wait_resp(lat);
        chk("fl_done_latency", 32'(lat), 32'd2);
        resp_ready = 1'b1;
        flush      = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        flush      = 1'b0;
        chk("fl_done_valid", {31'b0, resp_valid}, 32'd0);
        chk("fl_done_ready", {31'b0, req_ready},  32'd1);

        // Asynchronous reset mid-CALC
        issue(MULDIV_DIV, 1'b0, 1'b0, 32'd500, 32'd9, 6'd50);
        repeat (10) @(posedge clk);
        #2;
        chk("ar_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("ar_req_ready",  {31'b0, req_ready},  32'd1);
        chk("ar_busy",       {31'b0, busy},       32'd0);
        chk("ar_resp_data",  resp_data,           32'd0);
        chk("ar_resp_tag",   {26'b0, resp_tag},   32'd0);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            seen = seen | resp_valid;
        end
        chk("ar_no_resp", {31'b0, seen}, 32'd0);

        // Recovery after reset
        run_vec(vecs[0], 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
